// File: rtl/v_wb_pkg.sv
// Shared definitions for the vector writeback queue: SEW codes, source ids and the
// queue entry layout at the default register geometry.
package v_wb_pkg;

  localparam logic [1:0] SEW_8  = 2'b00;
  localparam logic [1:0] SEW_16 = 2'b01;
  localparam logic [1:0] SEW_32 = 2'b10;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;

  localparam int DEF_VREG_AW = 5;
  localparam int DEF_VREG_DW = 256;

  typedef struct packed {
    logic [DEF_VREG_AW-1:0] addr;
    logic [DEF_VREG_DW-1:0] data;
  } entry_t;

endpackage

// File: rtl/v_wb_rr_arb.sv
// Two-way round-robin arbiter between the vector ALU and vector memory result
// producers; the preference only rotates when both request in a granted cycle.
module v_wb_rr_arb
  import v_wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic pref_mem_q, pref_mem_d;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req[SRC_ALU] && req[SRC_MEM]) begin
        grant[pref_mem_q ? SRC_MEM : SRC_ALU] = 1'b1;
      end else begin
        grant = req;
      end
    end
  end

  always_comb begin
    pref_mem_d = pref_mem_q;
    if (en && req[SRC_ALU] && req[SRC_MEM]) pref_mem_d = ~pref_mem_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pref_mem_q <= 1'b1;
    else      pref_mem_q <= pref_mem_d;
  end

endmodule

// File: rtl/v_wb_queue.sv
// Vector writeback queue: arbitrates ALU/memory results into a DEPTH-entry FIFO that
// drains to the VRF write port. Define V_WB_PENDING_EN for the pending-write query port.
module v_wb_queue
  import v_wb_pkg::*;
#(
  parameter int VREG_DW = 256,
  parameter int VREG_AW = 5,
  parameter int REG_DW  = 32,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid_i,
  output logic                       alu_ready_o,
  input  logic [VREG_AW-1:0]         alu_addr_i,
  input  logic [VREG_DW-1:0]         alu_data_i,
  input  logic                       alu_from_rs1_i,
  input  logic [1:0]                 alu_sew_i,
  input  logic [REG_DW-1:0]          rs1_data_i,
  input  logic                       mem_valid_i,
  output logic                       mem_ready_o,
  input  logic [VREG_AW-1:0]         mem_addr_i,
  input  logic [VREG_DW-1:0]         mem_data_i,
  output logic                       vwb_en_o,
  output logic [VREG_AW-1:0]         vwb_addr_o,
  output logic [VREG_DW-1:0]         vwb_data_o,
  input  logic                       vwb_ready_i,
`ifdef V_WB_PENDING_EN
  input  logic [VREG_AW-1:0]         q_addr_i,
  output logic                       q_hit_o,
`endif
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [VREG_AW-1:0] addr;
    logic [VREG_DW-1:0] data;
  } q_entry_t;

  // Element width 11 falls back to 32-bit lanes.
  function automatic logic [VREG_DW-1:0] broadcast(input logic [REG_DW-1:0] rs1,
                                                   input logic [1:0] sew);
    logic [VREG_DW-1:0] res;
    case (sew)
      SEW_8:   res = {(VREG_DW/8){rs1[7:0]}};
      SEW_16:  res = {(VREG_DW/16){rs1[15:0]}};
      default: res = {(VREG_DW/32){rs1[31:0]}};
    endcase
    return res;
  endfunction

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  q_entry_t      ram_q [DEPTH];

  logic          full;
  logic [1:0]    req, grant;
  logic          push, pop;
  q_entry_t      push_entry;

  assign full = (count_q == FULL_CNT);
  assign req  = {mem_valid_i, alu_valid_i};

  // Held in reset, the arbiter grants nothing so both readys read 0.
  v_wb_rr_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .en    (rst && !full),
    .grant (grant)
  );

  assign alu_ready_o = grant[SRC_ALU];
  assign mem_ready_o = grant[SRC_MEM];
  assign push        = |grant;
  assign pop         = vwb_en_o && vwb_ready_i;

  always_comb begin
    push_entry = '0;
    if (grant[SRC_MEM]) begin
      push_entry.addr = mem_addr_i;
      push_entry.data = mem_data_i;
    end else begin
      push_entry.addr = alu_addr_i;
      push_entry.data = alu_from_rs1_i ? broadcast(rs1_data_i, alu_sew_i) : alu_data_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left uncleared by reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) ram_q[wr_ptr_q] <= push_entry;
  end

  assign vwb_en_o   = (count_q != '0);
  assign vwb_addr_o = vwb_en_o ? ram_q[rd_ptr_q].addr : '0;
  assign vwb_data_o = vwb_en_o ? ram_q[rd_ptr_q].data : '0;
  assign count_o    = count_q;

`ifdef V_WB_PENDING_EN
  logic [AW-1:0] slot_off;

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    q_hit_o  = 1'b0;
    slot_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = AW'(i) - rd_ptr_q;
      if (({1'b0, slot_off} < count_q) && (ram_q[i].addr == q_addr_i)) q_hit_o = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_v_wb_queue.sv
// Randomized self-checking bench for v_wb_queue against a queue-based reference model,
// plus directed literal checks. Pending-query checks are active with V_WB_PENDING_EN.
module tb_v_wb_queue;
  import v_wb_pkg::*;

  localparam int DW    = 256;
  localparam int AWD   = 5;
  localparam int RW    = 32;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           alu_valid_i = 1'b0, alu_ready_o, alu_from_rs1_i = 1'b0;
  logic [AWD-1:0] alu_addr_i = '0, mem_addr_i = '0, vwb_addr_o;
  logic [DW-1:0]  alu_data_i = '0, mem_data_i = '0, vwb_data_o;
  logic [1:0]     alu_sew_i = '0;
  logic [RW-1:0]  rs1_data_i = '0;
  logic           mem_valid_i = 1'b0, mem_ready_o;
  logic           vwb_en_o, vwb_ready_i = 1'b0;
  logic [2:0]     count_o;
  logic [AWD-1:0] q_addr_i = '0;
  logic           q_hit_o;

  v_wb_queue #(.VREG_DW(DW), .VREG_AW(AWD), .REG_DW(RW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid_i    (alu_valid_i),
    .alu_ready_o    (alu_ready_o),
    .alu_addr_i     (alu_addr_i),
    .alu_data_i     (alu_data_i),
    .alu_from_rs1_i (alu_from_rs1_i),
    .alu_sew_i      (alu_sew_i),
    .rs1_data_i     (rs1_data_i),
    .mem_valid_i    (mem_valid_i),
    .mem_ready_o    (mem_ready_o),
    .mem_addr_i     (mem_addr_i),
    .mem_data_i     (mem_data_i),
    .vwb_en_o       (vwb_en_o),
    .vwb_addr_o     (vwb_addr_o),
    .vwb_data_o     (vwb_data_o),
    .vwb_ready_i    (vwb_ready_i),
`ifdef V_WB_PENDING_EN
    .q_addr_i       (q_addr_i),
    .q_hit_o        (q_hit_o),
`endif
    .count_o        (count_o)
  );

`ifndef V_WB_PENDING_EN
  assign q_hit_o = 1'b0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  entry_t model_q[$];
  logic   pref_mem = 1'b1;
  logic   last_ar, last_mr;

  // Stimulus for the next cycle
  logic           av, mv, afr, vr;
  logic [AWD-1:0] aa, ma, qa;
  logic [DW-1:0]  ad, md;
  logic [1:0]     asew;
  logic [RW-1:0]  rs1v;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Each bit of the vector is the rs1 bit at the same position within its element.
  function automatic logic [DW-1:0] bcast(input logic [RW-1:0] rs1, input logic [1:0] sew);
    int w;
    logic [DW-1:0] r;
    w = (sew == 2'b00) ? 8 : (sew == 2'b01) ? 16 : 32;
    r = '0;
    for (int i = 0; i < DW; i++) r[i] = rs1[i % w];
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic set_idle();
    av = 0; mv = 0; afr = 0; vr = 1; aa = '0; ma = '0; qa = '0;
    ad = '0; md = '0; asew = '0; rs1v = '0;
  endtask

  // One clock cycle: drive, compare against model, advance the model at the edge.
  task automatic cycle();
    logic full, ea, em, hit;
    entry_t e;
    alu_valid_i = av; alu_addr_i = aa; alu_data_i = ad; alu_from_rs1_i = afr;
    alu_sew_i = asew; rs1_data_i = rs1v; mem_valid_i = mv; mem_addr_i = ma;
    mem_data_i = md; vwb_ready_i = vr; q_addr_i = qa;
    #1;
    chk("vwb_en", DW'(vwb_en_o), DW'(model_q.size() != 0));
    chk("vwb_addr", DW'(vwb_addr_o), (model_q.size() != 0) ? DW'(model_q[0].addr) : '0);
    chk("vwb_data", vwb_data_o, (model_q.size() != 0) ? model_q[0].data : '0);
    chk("count", DW'(count_o), DW'(model_q.size()));
`ifdef V_WB_PENDING_EN
    hit = 1'b0;
    foreach (model_q[i]) if (model_q[i].addr == qa) hit = 1'b1;
    chk("q_hit", DW'(q_hit_o), DW'(hit));
`endif
    full = (model_q.size() == DEPTH);
    ea = !full && av && (!mv || !pref_mem);
    em = !full && mv && (!av || pref_mem);
    chk("alu_ready", DW'(alu_ready_o), DW'(ea));
    chk("mem_ready", DW'(mem_ready_o), DW'(em));
    last_ar = alu_ready_o;
    last_mr = mem_ready_o;
    @(posedge clk);
    if (model_q.size() != 0 && vr) void'(model_q.pop_front());
    if (ea) begin
      e.addr = aa;
      e.data = afr ? bcast(rs1v, asew) : ad;
      model_q.push_back(e);
    end
    if (em) begin
      e.addr = ma;
      e.data = md;
      model_q.push_back(e);
    end
    if (av && mv && !full) pref_mem = !pref_mem;
    @(negedge clk);
  endtask

  // Reset asserted with both producers valid: every output must read 0 at once.
  task automatic do_reset();
    rst = 1'b0;
    alu_valid_i = 1'b1;
    mem_valid_i = 1'b1;
    #1;
    chk("rst_en", DW'(vwb_en_o), '0);
    chk("rst_addr", DW'(vwb_addr_o), '0);
    chk("rst_data", vwb_data_o, '0);
    chk("rst_count", DW'(count_o), '0);
    chk("rst_alu_ready", DW'(alu_ready_o), '0);
    chk("rst_mem_ready", DW'(mem_ready_o), '0);
    chk("rst_q_hit", DW'(q_hit_o), '0);
    model_q.delete();
    pref_mem = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] lit;
    logic [4:0] exp_m;
    chk("model_bcast16", bcast(32'h12345678, 2'b01), {16{16'h5678}});
    chk("model_bcast8", bcast(32'h12345678, 2'b00), {32{8'h78}});
    chk("model_bcast11", bcast(32'h12345678, 2'b11), {8{32'h12345678}});

    @(negedge clk);
    do_reset();
    set_idle();
    cycle();

    // Single ALU push, drained at once
    set_idle(); av = 1; aa = 5'd3; ad = {32{8'hA5}};
    cycle();
    lit = {32{8'hA5}};
    chk("lit_a5_en", DW'(vwb_en_o), DW'(1));
    chk("lit_a5_addr", DW'(vwb_addr_o), DW'(3));
    chk("lit_a5_data", vwb_data_o, lit);
    set_idle();
    cycle();
    chk("lit_a5_drained", DW'(count_o), '0);

    // Scalar broadcasts at 16- and 8-bit element widths
    set_idle(); av = 1; afr = 1; aa = 5'd9; rs1v = 32'h12345678; asew = 2'b01; ad = rnd256();
    cycle();
    lit = {16{16'h5678}};
    chk("lit_bcast16", vwb_data_o, lit);
    asew = 2'b00;
    cycle();
    lit = {32{8'h78}};
    chk("lit_bcast8", vwb_data_o, lit);
    set_idle();
    cycle();

    // Both sources contending from reset: mem, alu, mem, alu
    do_reset();
    exp_m = 5'b0101;
    for (int i = 0; i < 4; i++) begin
      set_idle(); av = 1; mv = 1; aa = AWD'(i); ma = AWD'(16 + i); ad = rnd256(); md = rnd256();
      cycle();
      chk("lit_rr_mem", DW'(last_mr), DW'(exp_m[i]));
      chk("lit_rr_alu", DW'(last_ar), DW'(!exp_m[i]));
    end
    set_idle();
    for (int i = 0; i < 3; i++) cycle();

    // Fill while the VRF stalls, then release
    for (int i = 1; i <= 5; i++) begin
      set_idle(); vr = 0; av = 1; aa = AWD'(i); ad = rnd256();
      cycle();
      chk("lit_fill_ready", DW'(last_ar), DW'(i <= 4));
    end
    chk("lit_full_count", DW'(count_o), DW'(4));
    chk("lit_full_head", DW'(vwb_addr_o), DW'(1));
    for (int i = 0; i < 6; i++) begin
      vr = 1; av = (i < 2);
      cycle();
    end

`ifdef V_WB_PENDING_EN
    // Pending-write query around a single queued write to v7
    do_reset();
    set_idle(); vr = 0; av = 1; aa = 5'd7; ad = rnd256();
    cycle();
    set_idle(); vr = 0; qa = 5'd7;
    cycle();
    chk("lit_hit7", DW'(q_hit_o), DW'(1));
    qa = 5'd8;
    cycle();
    chk("lit_hit8", DW'(q_hit_o), '0);
    qa = 5'd7; vr = 1;
    cycle();
    chk("lit_hit_after_pop", DW'(q_hit_o), '0);
    set_idle(); vr = 0; av = 1; aa = 5'd7;
    cycle();
    do_reset();
`endif

    // Randomized traffic with a reset in the middle
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      av   = ($urandom_range(0, 3) != 0);
      mv   = ($urandom_range(0, 2) != 0);
      afr  = ($urandom_range(0, 3) == 0);
      asew = 2'($urandom_range(0, 3));
      aa   = AWD'($urandom_range(0, 7));
      ma   = AWD'($urandom_range(0, 7));
      qa   = AWD'($urandom_range(0, 7));
      ad   = rnd256();
      md   = rnd256();
      rs1v = $urandom();
      vr   = ($urandom_range(0, 9) < 6);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/v_wb_queue.md
Name: v_wb_queue

Overview:
- Parametrised successor to the single-cycle vector writeback stage.
- Accepts vector results from two producers via valid/ready: the vector ALU (optionally a scalar broadcast) and vector memory.
- Round-robin arbitrates between them, buffers results in a DEPTH-entry FIFO, and drains one entry per cycle to the VRF write port, which can stall via vwb_ready_i.
- Sits between the two-issue vector execute/mem stages and the vector register file.

Parameters:
- VREG_DW, 256: vector register width, in bits.
- VREG_AW, 5: vector register address width.
- REG_DW, 32: scalar rs1 width.
- DEPTH, 4: FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset. Asynchronous, active-low.
- alu_valid_i, input, 1: ALU result valid.
- alu_ready_o, output, 1: ALU result accepted this cycle.
- alu_addr_i, input, VREG_AW: ALU destination vreg.
- alu_data_i, input, VREG_DW: ALU result.
- alu_from_rs1_i, input, 1: write a broadcast of rs1 instead of alu_data_i.
- alu_sew_i, input, 2: broadcast element width. 00=8, 01=16, 10=32, 11 is treated as 32.
- rs1_data_i, input, REG_DW: scalar broadcast source.
- mem_valid_i, input, 1: memory result valid.
- mem_ready_o, output, 1: memory result accepted this cycle.
- mem_addr_i, input, VREG_AW: memory destination vreg.
- mem_data_i, input, VREG_DW: load data.
- vwb_en_o, output, 1: VRF write request.
- vwb_addr_o, output, VREG_AW: VRF write address.
- vwb_data_o, output, VREG_DW: VRF write data.
- vwb_ready_i, input, 1: VRF port accepts the write this cycle.
- count_o, output, $clog2(DEPTH)+1: occupied FIFO entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - Read/write pointers and count go to 0.
  - Round-robin pointer goes to "mem preferred".
  - All outputs read 0.
- Push:
  - At most one push per cycle. No push when count==DEPTH.
  - Ready is computed from count only, not from a same-cycle pop.
  - Grant rules:
    - Only one source valid: that source is granted.
    - Both valid: the preferred source is granted. The pointer then flips to prefer the other source.
    - Pointer updates only on a two-way conflict.
  - alu_ready_o and mem_ready_o are asserted only for the granted source. They may depend combinationally on the valids.
- Broadcast:
  - When alu_from_rs1_i=1, the stored data is rs1_data_i[SEW-1:0] replicated VREG_DW/SEW times.
  - Replication is computed at push time; alu_data_i is ignored.
- Output:
  - vwb_en_o = (count!=0). vwb_addr_o and vwb_data_o come from the head entry and are forced to 0 when empty.
  - Pop on the edge where vwb_en_o && vwb_ready_i.
  - Head stays stable while vwb_ready_i=0.
- Latency:
  - A result pushed at edge N appears on vwb_en_o after edge N. Minimum latency is 1 cycle; no same-cycle fall-through.
- Simultaneous push and pop:
  - Allowed whenever not full; count is unchanged.
  - When full with a pop, the push is refused that cycle.
- Pointers wrap modulo DEPTH. count_o saturates naturally at DEPTH, since push is blocked when full.
- Program order within one source is preserved. Ordering across sources is arbitration order.
- Mid-operation reset: all FIFO contents are discarded and nothing is written. Stored data RAM need not be cleared.

Optional Feature:
- Macro: V_WB_PENDING_EN.
- When defined, adds two ports:
  - q_addr_i (input, VREG_AW): queried vreg address.
  - q_hit_o (output, 1): combinational, asserted when any occupied entry targets q_addr_i.
- Purpose: lets decode stall RAW hazards against queued writes. The head entry counts as occupied until the cycle it pops. q_hit_o reads 0 in reset.
- When undefined, neither port exists and no comparators are built.

Decomposition:
- Package v_wb_pkg holds:
  - SEW encodings: SEW_8=2'b00, SEW_16=2'b01, SEW_32=2'b10.
  - Entry typedef: addr plus data.
  - Source-id constants: SRC_ALU, SRC_MEM.
- One natural sub-module, v_wb_rr_arb: 2-way round-robin arbiter (req[1:0], en, grant[1:0], pointer register).
- FIFO storage and broadcast logic stay in the top.

Test Plan:
- Reset then idle: vwb_en_o=0, vwb_addr_o=0, vwb_data_o=0, count_o=0, both readys 0.
- ALU push, addr=3, data=all 0xA5, vwb_ready_i=1: one cycle later vwb_en_o=1, addr=3, data=all 0xA5; count returns to 0 after the pop.
- Broadcast, rs1=0x12345678, sew=01: data = 0x5678 repeated 16 times. With sew=00: 0x78 repeated 32 times.
- Both sources valid for 4 cycles after reset, vwb_ready_i=1: grants are mem, alu, mem, alu; VRF writes appear in the same order.
- vwb_ready_i=0 with 5 ALU pushes offered (DEPTH=4): 4 accepted, alu_ready_o=0 on the 5th; count_o=4; head unchanged. Release ready: 4 writes in FIFO order, then the 5th is accepted.
- V_WB_PENDING_EN defined: queue addr 7, q_addr_i=7 gives q_hit_o=1 and q_addr_i=8 gives 0. q_hit_o drops the cycle after addr 7 pops. Asserting rst mid-queue clears count_o and q_hit_o immediately.
